tcp_tx_arbiter: RTL
===================

# tcp_tx_arbiter

Packet-granular round-robin arbiter that shares the single 64-bit AXI-Stream MAC TX path among up to four frame generators: TCP link control frames, TCP data, ARP and ICMP. It also owns the IPv4 identification counter, advancing it once per completed IP frame, so all IP-carrying sources draw identifiers from one monotonic sequence. A beat-count watchdog bounds frame length so a misbehaving source cannot hold the MAC indefinitely.

## Interface

Parameters:
- NUM_SRC, 4: number of requesters. Legal range 2..4.
- IP_SRC_MASK, 4'b0111: bit i set means source i emits IPv4 frames and advances ip_identification.
- MAX_BEATS, 190: maximum accepted beats per frame (1518 B / 8, rounded up). Legal range 2..255.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- s_tdata  in  NUM_SRC*64  source i occupies bits [64i+63:64i]
- s_tkeep  in  NUM_SRC*8  source i occupies bits [8i+7:8i]
- s_tvalid  in  NUM_SRC  per-source valid
- s_tlast  in  NUM_SRC  per-source last
- s_tready  out  NUM_SRC  per-source ready
- m_tdata  out  64  to MAC TX
- m_tkeep  out  8  to MAC TX
- m_tvalid  out  1  to MAC TX
- m_tlast  out  1  to MAC TX
- m_tready  in  1  from MAC TX
- ip_identification  out  16  current IPv4 ID, sampled by the granted source
- grant  out  NUM_SRC  one-hot registered grant (all 0 when none)
- frame_err  out  1  one-cycle pulse on watchdog truncation

## Operation

- States: IDLE, XFER, DROP.
- IDLE:
  - grant = 0.
  - If any s_tvalid is high, pick the first set bit scanning from rr_ptr upward, modulo NUM_SRC.
  - At the clock edge: grant <= onehot(winner), rr_ptr <= (winner+1) mod NUM_SRC, beat_cnt <= 0, state <= XFER.
- XFER, granted source g:
  - m_* = source g's signals (combinational mux on the registered grant).
  - s_tready[g] = m_tready; all other s_tready = 0.
  - On each accepted beat (m_tvalid & m_tready): beat_cnt <= beat_cnt+1.
  - On an accepted beat with s_tlast[g]: grant <= 0, state <= IDLE. If IP_SRC_MASK[g] is set, ip_identification <= ip_identification+1 (wraps 0xFFFF→0x0000).
  - On the accepted beat where beat_cnt == MAX_BEATS-1 and s_tlast[g] = 0:
    - m_tlast is forced to 1 on that beat.
    - frame_err pulses for one cycle.
    - ip_identification is not advanced.
    - state <= DROP; grant is held.
- DROP:
  - m_tvalid = 0.
  - s_tready[g] = 1, discarding source g's beats until one is accepted with s_tlast[g].
  - Then grant <= 0, state <= IDLE.
- When no grant is active: m_tvalid = m_tlast = 0, m_tdata = 0, m_tkeep = 0.
- ip_identification changes only on the frame-ending edge, so it is stable for the entire frame of the granted source.
- Sources obey AXI-Stream: tdata, tkeep and tlast are held while tvalid & !tready. A source that deasserts tvalid mid-frame simply stalls the arbiter; this is not an error.

## Timing

- Reset values: state = IDLE, grant = 0, rr_ptr = 0, beat_cnt = 0, ip_identification = 0, frame_err = 0, and all s_tready and m_* outputs = 0.
- Reset asserted mid-frame abandons the frame with no forced tlast. Upstream and MAC are reset by the same areset.
- Arbitration latency: s_tvalid rising in IDLE gives grant and the first possible transfer on the next cycle.
- Inter-frame gap: a frame-ending beat returns the arbiter to IDLE. Minimum one idle cycle between frames, even with requests pending.
- m_tready → s_tready path is combinational; the m_* outputs are combinational from the mux, with zero added latency.
- Requests that arrive on the same cycle as a frame end are arbitrated in the following IDLE cycle.
- Rotation: when all sources request continuously, grants follow rr_ptr order 0, 1, 2, 3, 0, …
- A single-beat frame (tlast on the first beat) is legal and counts toward ip_identification.

## Test plan

- Single source 1 sends a 7-beat frame with m_tready = 1 → grant = 4'b0010 one cycle after s_tvalid; 7 beats pass unchanged; m_tlast on beat 7; ip_identification goes 0→1.
- All four sources request continuously, each sending 3-beat frames → grant order 0, 1, 2, 3, 0; one idle cycle between frames; ip_identification = 3 after the first four frames (source 3 is not in the mask).
- m_tready toggles 1, 0, 1, 0 during a frame from source 0 → no beat duplicated or lost; s_tready[0] mirrors m_tready; m_tdata is held while stalled.
- Source 2 sends 200 beats without tlast, with MAX_BEATS = 190 → beat 190 is output with m_tlast = 1; frame_err pulses once; beats 191..200 are absorbed with m_tvalid = 0; ip_identification is unchanged; next grant goes to the next requester.
- ip_identification preloaded to 0xFFFF by issuing 65535 single-beat source 0 frames, then one more → wraps to 0x0000.
- areset asserted on the 3rd beat of a frame → next cycle grant = 0, m_tvalid = 0, ip_identification = 0, rr_ptr = 0; the first request afterwards from sources 1 and 3 grants source 1.

Source files
------------

// File: rtl/tcp_tx_arbiter.sv
// Packet round-robin arbiter sharing the MAC TX stream among NUM_SRC sources; owns the IPv4 ID counter.
// Latency: grant one cycle after request, then zero-latency data mux; m_tready feeds s_tready combinationally.
module tcp_tx_arbiter #(
  parameter int         NUM_SRC     = 4,
  parameter logic [3:0] IP_SRC_MASK = 4'b0111,
  parameter int         MAX_BEATS   = 190
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NUM_SRC*64-1:0]  s_tdata,
  input  logic [NUM_SRC*8-1:0]   s_tkeep,
  input  logic [NUM_SRC-1:0]     s_tvalid,
  input  logic [NUM_SRC-1:0]     s_tlast,
  output logic [NUM_SRC-1:0]     s_tready,
  output logic [63:0]            m_tdata,
  output logic [7:0]             m_tkeep,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [15:0]            ip_identification,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   frame_err
);

  localparam int IW = (NUM_SRC > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q;
  logic [IW-1:0]      gidx_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [7:0]         beat_cnt_q;
  logic [15:0]        ip_id_q;
  logic               frame_err_q;

  logic               win_vld;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      win_next;

  logic [63:0]        sel_data;
  logic [7:0]         sel_keep;
  logic               sel_vld;
  logic               sel_last;

  logic               wd_hit;
  logic               beat_acc;
  logic               frame_end;
  logic               trunc;
  logic               drop_end;

  // Source selected by the registered grant index.
  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_data = s_tdata[64*i +: 64];
        sel_keep = s_tkeep[8*i +: 8];
        sel_vld  = s_tvalid[i];
        sel_last = s_tlast[i];
      end
    end
  end

  // First requester at or above rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int cand;
      cand = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!win_vld && s_tvalid[cand]) begin
        win_vld = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  assign win_next  = (win_idx == IW'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;

  assign wd_hit    = (beat_cnt_q == 8'(MAX_BEATS - 1));
  assign beat_acc  = (state_q == XFER) && sel_vld && m_tready;
  assign frame_end = beat_acc && sel_last;
  assign trunc     = beat_acc && !sel_last && wd_hit;
  assign drop_end  = (state_q == DROP) && sel_vld && sel_last;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = XFER;
      XFER: begin
        if (frame_end)  state_d = IDLE;
        else if (trunc) state_d = DROP;
      end
      DROP:    if (drop_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet during reset so a frame cut by areset emits nothing more.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (!areset) begin
      case (state_q)
        XFER: begin
          m_tdata  = sel_data;
          m_tkeep  = sel_keep;
          m_tvalid = sel_vld;
          m_tlast  = sel_last | wd_hit;
          for (int i = 0; i < NUM_SRC; i++)
            if (gidx_q == IW'(i)) s_tready[i] = m_tready;
        end
        DROP: begin
          for (int i = 0; i < NUM_SRC; i++)
            if (gidx_q == IW'(i)) s_tready[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant             = grant_q;
  assign ip_identification = ip_id_q;
  assign frame_err         = frame_err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      ip_id_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= trunc;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q    <= NUM_SRC'(1) << win_idx;
            gidx_q     <= win_idx;
            rr_ptr_q   <= win_next;
            beat_cnt_q <= '0;
          end
        end
        XFER: begin
          if (beat_acc) beat_cnt_q <= beat_cnt_q + 8'd1;
          // Truncated frames keep the grant through DROP and do not consume an ID.
          if (frame_end) begin
            grant_q <= '0;
            if (IP_SRC_MASK[gidx_q]) ip_id_q <= ip_id_q + 16'd1;
          end
        end
        DROP: begin
          if (drop_end) grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
